// File: rtl/rggen_avalon_adapter.sv
// Avalon-MM agent front end for an rggen register block: accepts one command at a
// time, optionally checks the address window, and drives the rggen internal bus.
module rggen_avalon_adapter #(
    parameter int                     ADDRESS_WIDTH       = 8,
    parameter int                     LOCAL_ADDRESS_WIDTH = 8,
    parameter int                     BUS_WIDTH           = 32,
    parameter bit                     READ_STROBE         = 1'b1,
    parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = {ADDRESS_WIDTH{1'b0}},
    parameter bit                     ERROR_STATUS        = 1'b0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_read,
    input  logic                           i_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_address,
    input  logic [BUS_WIDTH/8-1:0]         i_byteenable,
    input  logic [BUS_WIDTH-1:0]           i_writedata,
    output logic                           o_waitrequest,
    output logic                           o_readdatavalid,
    output logic                           o_writeresponsevalid,
    output logic [1:0]                     o_response,
    output logic [BUS_WIDTH-1:0]           o_readdata,
    output logic                           o_bus_valid,
    output logic [1:0]                     o_bus_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [BUS_WIDTH-1:0]           o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_bus_strobe,
    input  logic                           i_bus_ready,
    input  logic [1:0]                     i_bus_status,
    input  logic [BUS_WIDTH-1:0]           i_bus_read_data
);

    localparam int STRB_W = BUS_WIDTH / 8;
    localparam logic [1:0] ACCESS_READ   = 2'b10;
    localparam logic [1:0] ACCESS_WRITE  = 2'b11;
    localparam logic [1:0] RESP_DECERR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e                         state_r, state_s;
    logic                           accept_s;
    logic                           decode_error_s;
    logic                           bus_valid_r, bus_valid_s;
    logic [1:0]                     access_r, access_s;
    logic [LOCAL_ADDRESS_WIDTH-1:0] address_r, address_s;
    logic [BUS_WIDTH-1:0]           write_data_r, write_data_s;
    logic [STRB_W-1:0]              strobe_r, strobe_s;
    logic [1:0]                     response_r, response_s;
    logic [BUS_WIDTH-1:0]           read_data_r, read_data_s;
    logic                           rdv_r, rdv_s;
    logic                           wrv_r, wrv_s;

    // Only the bits above the local window take part in the window compare.
    generate
        if (ERROR_STATUS && (ADDRESS_WIDTH > LOCAL_ADDRESS_WIDTH)) begin : g_window
            assign decode_error_s =
                (i_address[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH] !=
                 BASE_ADDRESS[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH]);
        end else begin : g_no_window
            assign decode_error_s = 1'b0;
        end
    endgenerate

    assign accept_s = (state_r == IDLE) && (i_read || i_write);

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= IDLE;
            bus_valid_r  <= 1'b0;
            access_r     <= 2'b00;
            address_r    <= {LOCAL_ADDRESS_WIDTH{1'b0}};
            write_data_r <= {BUS_WIDTH{1'b0}};
            strobe_r     <= {STRB_W{1'b0}};
            response_r   <= 2'b00;
            read_data_r  <= {BUS_WIDTH{1'b0}};
            rdv_r        <= 1'b0;
            wrv_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            bus_valid_r  <= bus_valid_s;
            access_r     <= access_s;
            address_r    <= address_s;
            write_data_r <= write_data_s;
            strobe_r     <= strobe_s;
            response_r   <= response_s;
            read_data_r  <= read_data_s;
            rdv_r        <= rdv_s;
            wrv_r        <= wrv_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = decode_error_s ? RESPOND : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (i_bus_ready) begin
                    state_s = RESPOND;
                end else begin
                    state_s = BUSY;
                end
            end
            RESPOND: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; response strobes last one cycle.
    always_comb begin
        bus_valid_s  = 1'b0;
        access_s     = access_r;
        address_s    = address_r;
        write_data_s = write_data_r;
        strobe_s     = strobe_r;
        response_s   = response_r;
        read_data_s  = read_data_r;
        rdv_s        = 1'b0;
        wrv_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    access_s     = i_read ? ACCESS_READ : ACCESS_WRITE;
                    address_s    = i_address[LOCAL_ADDRESS_WIDTH-1:0];
                    write_data_s = i_writedata;
                    if (i_read && (READ_STROBE == 1'b0)) begin
                        strobe_s = {STRB_W{1'b1}};
                    end else begin
                        strobe_s = i_byteenable;
                    end
                    if (decode_error_s) begin
                        response_s  = RESP_DECERR;
                        read_data_s = {BUS_WIDTH{1'b0}};
                        rdv_s       = i_read;
                        wrv_s       = ~i_read;
                    end else begin
                        bus_valid_s = 1'b1;
                    end
                end else begin
                    bus_valid_s = 1'b0;
                end
            end
            BUSY: begin
                if (i_bus_ready) begin
                    response_s  = i_bus_status;
                    read_data_s = (access_r == ACCESS_READ) ? i_bus_read_data : {BUS_WIDTH{1'b0}};
                    rdv_s       = (access_r == ACCESS_READ);
                    wrv_s       = (access_r != ACCESS_READ);
                end else begin
                    bus_valid_s = 1'b1;
                end
            end
            RESPOND: bus_valid_s = 1'b0;
            default: bus_valid_s = 1'b0;
        endcase
    end

    assign o_waitrequest        = (state_r != IDLE);
    assign o_readdatavalid      = rdv_r;
    assign o_writeresponsevalid = wrv_r;
    assign o_response           = response_r;
    assign o_readdata           = read_data_r;
    assign o_bus_valid          = bus_valid_r;
    assign o_bus_access         = access_r;
    assign o_bus_address        = address_r;
    assign o_bus_write_data     = write_data_r;
    assign o_bus_strobe         = strobe_r;

endmodule

// File: tb/tb_rggen_avalon_adapter.sv
// Bench for rggen_avalon_adapter: windowed instance (a) and READ_STROBE=0 instance (b)
// share all inputs; vector table plus hand-written reset sequence, scoreboarded responses.
module tb_rggen_avalon_adapter;

    logic        clk;
    logic        i_rst;
    logic        i_read, i_write;
    logic [15:0] i_address;
    logic [3:0]  i_byteenable;
    logic [31:0] i_writedata;
    logic        i_bus_ready;
    logic [1:0]  i_bus_status;
    logic [31:0] i_bus_read_data;

    logic        wait_a, rdv_a, wrv_a, bv_a;
    logic [1:0]  resp_a, acc_a;
    logic [31:0] rdata_a, wd_a;
    logic [7:0]  addr_a;
    logic [3:0]  strb_a;

    logic        wait_b, rdv_b, wrv_b, bv_b;
    logic [1:0]  resp_b, acc_b;
    logic [31:0] rdata_b, wd_b;
    logic [7:0]  addr_b;
    logic [3:0]  strb_b;

    rggen_avalon_adapter #(
        .ADDRESS_WIDTH(16), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32),
        .READ_STROBE(1'b1), .BASE_ADDRESS(16'h0100), .ERROR_STATUS(1'b1)
    ) dut_a (
        .i_clk(clk), .i_rst(i_rst), .i_read(i_read), .i_write(i_write),
        .i_address(i_address), .i_byteenable(i_byteenable), .i_writedata(i_writedata),
        .o_waitrequest(wait_a), .o_readdatavalid(rdv_a), .o_writeresponsevalid(wrv_a),
        .o_response(resp_a), .o_readdata(rdata_a), .o_bus_valid(bv_a),
        .o_bus_access(acc_a), .o_bus_address(addr_a), .o_bus_write_data(wd_a),
        .o_bus_strobe(strb_a), .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status),
        .i_bus_read_data(i_bus_read_data)
    );

    rggen_avalon_adapter #(
        .ADDRESS_WIDTH(16), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32),
        .READ_STROBE(1'b0), .BASE_ADDRESS(16'h0000), .ERROR_STATUS(1'b0)
    ) dut_b (
        .i_clk(clk), .i_rst(i_rst), .i_read(i_read), .i_write(i_write),
        .i_address(i_address), .i_byteenable(i_byteenable), .i_writedata(i_writedata),
        .o_waitrequest(wait_b), .o_readdatavalid(rdv_b), .o_writeresponsevalid(wrv_b),
        .o_response(resp_b), .o_readdata(rdata_b), .o_bus_valid(bv_b),
        .o_bus_access(acc_b), .o_bus_address(addr_b), .o_bus_write_data(wd_b),
        .o_bus_strobe(strb_b), .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status),
        .i_bus_read_data(i_bus_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [1:0]  status;
        logic [31:0] rdata;
        logic        decerr;
        logic [1:0]  exp_access;
        logic [3:0]  exp_strb_a;
        logic [3:0]  exp_strb_b;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_read;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response strobe of instance a must match the oldest expectation.
    always @(negedge clk) begin
        if (rdv_a || wrv_a) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_response: got rdv=%0b wrv=%0b, expected none", rdv_a, wrv_a);
            end else begin
                mon_e = sb.pop_front();
                check("resp_rdv", 32'(rdv_a), 32'(mon_e.is_read));
                check("resp_wrv", 32'(wrv_a), 32'(!mon_e.is_read));
                check("response", 32'(resp_a), 32'(mon_e.resp));
                check("readdata", rdata_a, mon_e.rdata);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check("idle_waitreq", 32'(wait_a), 32'd0);
        i_read       = v.rd;
        i_write      = v.wr;
        i_address    = v.addr;
        i_byteenable = v.be;
        i_writedata  = v.wdata;
        sb.push_back('{v.rd, v.exp_resp, v.exp_rdata});
        @(negedge clk);
        i_read  = 1'b0;
        i_write = 1'b0;
        check("waitreq_after_accept", 32'(wait_a), 32'd1);
        if (v.decerr) begin
            check("decerr_no_valid", 32'(bv_a), 32'd0);
            @(negedge clk);
            check("decerr_no_valid_2", 32'(bv_a), 32'd0);
            check("decerr_idle", 32'(wait_a), 32'd0);
            // instance b is busy with the same command; ready must be ignored by a
            i_bus_ready = 1'b1;
            @(negedge clk);
            i_bus_ready = 1'b0;
        end else begin
            for (int c = 0; c <= v.delay; c++) begin
                if (c > 0) @(negedge clk);
                check("bus_valid", 32'(bv_a), 32'd1);
                check("bus_access", 32'(acc_a), 32'(v.exp_access));
                check("bus_address", 32'(addr_a), 32'(v.addr[7:0]));
                check("bus_write_data", wd_a, v.wdata);
                check("bus_strobe_a", 32'(strb_a), 32'(v.exp_strb_a));
                check("bus_strobe_b", 32'(strb_b), 32'(v.exp_strb_b));
                check("busy_waitreq", 32'(wait_a), 32'd1);
            end
            i_bus_ready     = 1'b1;
            i_bus_status    = v.status;
            i_bus_read_data = v.rdata;
            @(negedge clk);
            i_bus_ready     = 1'b0;
            i_bus_status    = 2'b00;
            i_bus_read_data = 32'h0;
            check("respond_no_valid", 32'(bv_a), 32'd0);
            check("respond_waitreq", 32'(wait_a), 32'd1);
        end
        @(negedge clk);
        #1;
        check("response_seen", 32'(sb.size()), 32'd0);
        check("readdata_hold", rdata_a, v.exp_rdata);
        check("response_hold", 32'(resp_a), 32'(v.exp_resp));
        check("back_idle", 32'(wait_a), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'h0110, 4'b0011, 32'h00000000, 0, 2'b00, 32'h12345678,
                    1'b0, 2'b10, 4'b0011, 4'b1111, 2'b00, 32'h12345678};
        vecs[1] = '{1'b0, 1'b1, 16'h0104, 4'b1111, 32'hCAFEF00D, 2, 2'b00, 32'h00000000,
                    1'b0, 2'b11, 4'b1111, 4'b1111, 2'b00, 32'h00000000};
        vecs[2] = '{1'b0, 1'b1, 16'h0108, 4'b0100, 32'h000055AA, 1, 2'b10, 32'hDEADBEEF,
                    1'b0, 2'b11, 4'b0100, 4'b0100, 2'b10, 32'h00000000};
        vecs[3] = '{1'b1, 1'b1, 16'h01FC, 4'b0001, 32'hFFFFFFFF, 0, 2'b00, 32'hA5A5A5A5,
                    1'b0, 2'b10, 4'b0001, 4'b1111, 2'b00, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 1'b0, 16'h0200, 4'b1111, 32'h00000000, 0, 2'b00, 32'h00000000,
                    1'b1, 2'b10, 4'b1111, 4'b1111, 2'b11, 32'h00000000};
        vecs[5] = '{1'b1, 1'b0, 16'h0100, 4'b1000, 32'h00000000, 1, 2'b10, 32'h0BADF00D,
                    1'b0, 2'b10, 4'b1000, 4'b1111, 2'b10, 32'h0BADF00D};
        vecs[6] = '{1'b0, 1'b1, 16'hFF00, 4'b1111, 32'h11112222, 0, 2'b00, 32'h00000000,
                    1'b1, 2'b11, 4'b1111, 4'b1111, 2'b11, 32'h00000000};
        vecs[7] = '{1'b0, 1'b1, 16'h01FF, 4'b0110, 32'h87654321, 0, 2'b01, 32'h00000000,
                    1'b0, 2'b11, 4'b0110, 4'b0110, 2'b01, 32'h00000000};

        i_rst = 1'b1; i_read = 1'b0; i_write = 1'b0; i_address = 16'h0;
        i_byteenable = 4'h0; i_writedata = 32'h0;
        i_bus_ready = 1'b0; i_bus_status = 2'b00; i_bus_read_data = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_waitreq", 32'(wait_a), 32'd0);
        check("rst_bus_valid", 32'(bv_a), 32'd0);
        check("rst_rdv", 32'(rdv_a), 32'd0);
        check("rst_wrv", 32'(wrv_a), 32'd0);
        check("rst_response", 32'(resp_a), 32'd0);
        check("rst_readdata", rdata_a, 32'd0);
        check("rst_access", 32'(acc_a), 32'd0);
        check("rst_strobe", 32'(strb_a), 32'd0);
        i_rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while BUSY: in-flight read dropped, no response afterwards.
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h0120; i_byteenable = 4'b1111;
        @(negedge clk);
        i_read = 1'b0;
        check("rstmid_busy", 32'(bv_a), 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("rstmid_bus_valid", 32'(bv_a), 32'd0);
        check("rstmid_waitreq", 32'(wait_a), 32'd0);
        check("rstmid_rdv", 32'(rdv_a), 32'd0);
        check("rstmid_wrv", 32'(wrv_a), 32'd0);
        i_bus_ready = 1'b1; i_bus_read_data = 32'hFFFF0000;
        @(negedge clk);
        i_bus_ready = 1'b0; i_bus_read_data = 32'h0;
        check("rstmid_ready_ignored", 32'(wait_a), 32'd0);
        repeat (2) @(negedge clk);

        run_vec(vecs[0]);

        repeat (2) @(negedge clk);
        check("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
